// File: rtl/token_arbiter_pkg.sv
// Shared definitions for the two-source token arbiter: lock-state encoding
// and the default token delimiter.
package token_arbiter_pkg;

   // The encoding doubles as the owner output: {locked, src}.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      LOCK0 = 2'b10,
      LOCK1 = 2'b11
   } state_t;

   localparam logic [7:0] SPACE_DEFAULT = 8'h20;

endpackage

// File: rtl/token_arbiter_sat_counter.sv
// Saturating up-counter used to count completed tokens for one source.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/token_arbiter.sv
// Shares one downstream keyword checker between two character streams,
// locking the output to a source for the whole of each token.
module token_arbiter
   import token_arbiter_pkg::*;
#(
   parameter int         CNT_W = 16,
   parameter logic [7:0] SPACE = SPACE_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_valid,
   input  logic [7:0]       in0_char,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [7:0]       in1_char,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [7:0]       out_char,
   output logic             out_src,
   input  logic             out_ready,
   output logic [CNT_W-1:0] tok_cnt0,
   output logic [CNT_W-1:0] tok_cnt1,
   output logic [1:0]       owner
);

   state_t     state, state_nxt;
   logic       rr, rr_nxt;
   logic [1:0] in_word;
   logic       sel, sel_en;
   logic       slot_free;
   logic       accept;
   logic [7:0] acc_char;
   logic       acc_space;
   logic       inc0, inc1;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sel    = 1'b0;
      sel_en = 1'b0;
      case (state)
         LOCK0: begin
            sel    = 1'b0;
            sel_en = 1'b1;
         end
         LOCK1: begin
            sel    = 1'b1;
            sel_en = 1'b1;
         end
         default: begin
            if (in0_valid && in1_valid) begin
               sel    = rr;
               sel_en = 1'b1;
            end else if (in1_valid) begin
               sel    = 1'b1;
               sel_en = 1'b1;
            end else if (in0_valid) begin
               sel    = 1'b0;
               sel_en = 1'b1;
            end
         end
      endcase
   end

   assign slot_free = !out_valid || out_ready;

   // Ready is gated by reset so neither source sees a grant while reset is held.
   assign in0_ready = reset && slot_free && sel_en && !sel;
   assign in1_ready = reset && slot_free && sel_en &&  sel;

   assign accept    = sel ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
   assign acc_char  = sel ? in1_char : in0_char;
   assign acc_space = (acc_char == SPACE);

   always_comb begin
      state_nxt = state;
      rr_nxt    = rr;
      if (accept) begin
         if (acc_space) begin
            state_nxt = IDLE;
            rr_nxt    = !sel;
         end else begin
            state_nxt = sel ? LOCK1 : LOCK0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rr      <= 1'b0;
         in_word <= 2'b00;
      end else begin
         state <= state_nxt;
         rr    <= rr_nxt;
         if (accept) begin
            in_word[sel] <= !acc_space;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_char  <= 8'h00;
         out_src   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_char  <= acc_char;
         out_src   <= sel;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // A token completes on the first space after at least one non-space.
   assign inc0 = accept && !sel && acc_space && in_word[0];
   assign inc1 = accept &&  sel && acc_space && in_word[1];

   sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
      .clk   (clk),
      .reset (reset),
      .inc   (inc0),
      .count (tok_cnt0)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
      .clk   (clk),
      .reset (reset),
      .inc   (inc1),
      .count (tok_cnt1)
   );

   assign owner = state;

endmodule

// File: tb/tb_token_arbiter.sv
// Self-checking bench for token_arbiter: a token-level reference model checked
// every cycle, plus directed scenarios with literal expected streams and counts.
module tb_token_arbiter;

   localparam int         CNT_W   = 3;
   localparam int         CNT_MAX = (1 << CNT_W) - 1;
   localparam logic [7:0] SP      = 8'h20;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             in0_valid = 1'b0, in1_valid = 1'b0;
   logic [7:0]       in0_char = 8'h00, in1_char = 8'h00;
   logic             in0_ready, in1_ready;
   logic             out_valid;
   logic [7:0]       out_char;
   logic             out_src;
   logic             out_ready = 1'b1;
   logic [CNT_W-1:0] tok_cnt0, tok_cnt1;
   logic [1:0]       owner;

   token_arbiter #(.CNT_W(CNT_W), .SPACE(SP)) dut (
      .clk       (clk),
      .reset     (reset),
      .in0_valid (in0_valid),
      .in0_char  (in0_char),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_char  (in1_char),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_char  (out_char),
      .out_src   (out_src),
      .out_ready (out_ready),
      .tok_cnt0  (tok_cnt0),
      .tok_cnt1  (tok_cnt1),
      .owner     (owner)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: owner source (-1 = nobody), round-robin preference,
   // per-source "inside a word" flags and token counts, and the output slot.
   int         m_own  = -1;
   int         m_rr   = 0;
   bit         m_word [2] = '{0, 0};
   int         m_cnt  [2] = '{0, 0};
   bit         m_ov   = 0;
   logic [7:0] m_oc   = 8'h00;
   bit         m_os   = 0;

   bit         p_acc  = 0;
   int         p_src  = 0;
   logic [7:0] p_chr  = 8'h00;
   bit         p_drop = 0;

   logic [8:0] log_q[$];

   always @(negedge clk) begin
      int sel;
      bit sf;
      if (!reset) begin
         m_own = -1; m_rr = 0; m_word = '{0, 0}; m_cnt = '{0, 0};
         m_ov = 0; m_oc = 8'h00; m_os = 0;
      end
      sf  = !m_ov || out_ready;
      sel = -1;
      if (reset) begin
         if (m_own >= 0)                  sel = m_own;
         else if (in0_valid && in1_valid) sel = m_rr;
         else if (in0_valid)              sel = 0;
         else if (in1_valid)              sel = 1;
      end
      check("in0_ready", in0_ready, reset && sf && sel == 0);
      check("in1_ready", in1_ready, reset && sf && sel == 1);
      check("out_valid", out_valid, m_ov);
      if (m_ov || !reset) begin
         check("out_char", out_char, m_oc);
         check("out_src", out_src, m_os);
      end
      check("tok_cnt0", tok_cnt0, m_cnt[0]);
      check("tok_cnt1", tok_cnt1, m_cnt[1]);
      check("owner", owner, (m_own < 0) ? 0 : 2 + m_own);
      if (reset && out_valid && out_ready) log_q.push_back({out_src, out_char});
      p_acc  = sf && (sel == 0 ? in0_valid : (sel == 1 ? in1_valid : 1'b0));
      p_src  = sel;
      p_chr  = (sel == 1) ? in1_char : in0_char;
      p_drop = out_ready;
   end

   always @(posedge clk) begin
      if (reset) begin
         if (p_acc) begin
            m_ov = 1; m_oc = p_chr; m_os = p_src[0];
            if (p_chr == SP) begin
               if (m_word[p_src] && m_cnt[p_src] < CNT_MAX) m_cnt[p_src]++;
               m_word[p_src] = 0;
               m_own = -1;
               m_rr  = 1 - p_src;
            end else begin
               m_word[p_src] = 1;
               m_own = p_src;
            end
         end else if (p_drop) begin
            m_ov = 0;
         end
      end
      p_acc = 0;
   end

   // Stimulus runs at 1 time unit after each rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic send(input string s0, input string s1, input int max_cyc,
                       input int stall_start, input int stall_len,
                       output int done0, output int done1);
      int  i0, i1;
      bit  a0, a1;
      i0 = 0;
      i1 = 0;
      for (int c = 0; c < max_cyc && (i0 < s0.len() || i1 < s1.len()); c++) begin
         in0_valid = (i0 < s0.len());
         in0_char  = in0_valid ? s0[i0] : 8'h00;
         in1_valid = (i1 < s1.len());
         in1_char  = in1_valid ? s1[i1] : 8'h00;
         out_ready = !(c >= stall_start && c < stall_start + stall_len);
         @(negedge clk);
         a0 = in0_valid && in0_ready;
         a1 = in1_valid && in1_ready;
         @(posedge clk);
         #1;
         if (a0) i0++;
         if (a1) i1++;
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      done0 = i0;
      done1 = i1;
   endtask

   task automatic check_log(input string name, input string chars, input string srcs);
      logic [8:0] e;
      check({name, " length"}, log_q.size(), chars.len());
      for (int i = 0; i < chars.len() && i < log_q.size(); i++) begin
         e = {srcs[i] == 8'h31, chars[i]};
         check(name, log_q[i], e);
      end
      log_q.delete();
   endtask

   initial begin
      int d0, d1;

      // Both sources valid while reset is held: no grant, everything cleared.
      in0_valid = 1'b1; in0_char = "a";
      in1_valid = 1'b1; in1_char = "c";
      @(posedge clk);
      #1;
      check("reset in0_ready", in0_ready, 0);
      check("reset in1_ready", in1_ready, 0);
      check("reset out_valid", out_valid, 0);
      check("reset owner", owner, 0);
      check("reset tok_cnt0", tok_cnt0, 0);
      @(posedge clk);
      #1 reset = 1'b1;

      // Two full tokens contend; source 0 wins first and keeps the lock.
      send("ab ", "cd ", 40, 99, 0, d0, d1);
      idle(2);
      check_log("two-source order", "ab cd ", "000111");
      check("two-source tok_cnt0", tok_cnt0, 1);
      check("two-source tok_cnt1", tok_cnt1, 1);

      // Single source, two tokens.
      do_reset();
      send("be g ", "", 40, 99, 0, d0, d1);
      idle(2);
      check_log("src0 only", "be g ", "00000");
      check("src0 only tok_cnt0", tok_cnt0, 2);
      check("src0 only tok_cnt1", tok_cnt1, 0);

      // Source 1 pauses mid-token; source 0 must wait for its space.
      do_reset();
      send("", "xy", 20, 99, 0, d0, d1);
      check("src1 partial sent", d1, 2);
      send("k ", "", 5, 99, 0, d0, d1);
      check("src0 blocked by lock", d0, 0);
      check("owner locked to src1", owner, 2'b11);
      send("k ", " ", 20, 99, 0, d0, d1);
      idle(2);
      check_log("lock hold", "xy k ", "11100");
      check("lock hold tok_cnt1", tok_cnt1, 1);

      // Downstream stall for three cycles while a character is held.
      do_reset();
      send("pq ", "", 30, 1, 3, d0, d1);
      idle(2);
      check_log("stall", "pq ", "000");
      check("stall tok_cnt0", tok_cnt0, 1);

      // Leading and repeated spaces count nothing extra.
      do_reset();
      send("  x  ", "", 30, 99, 0, d0, d1);
      idle(2);
      check_log("spaces", "  x  ", "00000");
      check("spaces tok_cnt0", tok_cnt0, 1);

      // Ten tokens saturate the narrow counter; case passes through unchanged.
      do_reset();
      send("A b C d e f g h i j ", "", 100, 99, 0, d0, d1);
      idle(2);
      check_log("saturate", "A b C d e f g h i j ", "00000000000000000000");
      check("saturate tok_cnt0", tok_cnt0, CNT_MAX);

      // Reset while locked to source 1 with a character pending.
      do_reset();
      send("", "mn", 20, 99, 0, d0, d1);
      check("pre-reset out_valid", out_valid, 1);
      check("pre-reset owner", owner, 2'b11);
      reset = 1'b0;
      #1;
      check("mid-token reset out_valid", out_valid, 0);
      check("mid-token reset owner", owner, 0);
      check("mid-token reset tok_cnt1", tok_cnt1, 0);
      @(posedge clk);
      #1 reset = 1'b1;
      check_log("discarded token", "m", "1");
      send("u ", "v ", 40, 99, 0, d0, d1);
      idle(2);
      check_log("after reset", "u v ", "0011");
      check("after reset tok_cnt1", tok_cnt1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
